// File: rtl/mvm_y_collector.sv
// Purpose: captures the K-entry y result that the upstream mvm block streams out
//          after its done pulse, then replays it to a valid/ready consumer.
// Latency: first out_valid K+1 cycles after done; K beats in K cycles when out_ready stays high.
// Backpressure: out_ready low stalls DRAIN with out_data/out_index held; capture itself never stalls,
//          so a done that arrives while busy is dropped and recorded in the sticky overflow flag.
//
// Ports:
//   clk, reset (async, active-low)
//   done, data_in             : upstream result stream (done pulse, then K values on consecutive cycles)
//   out_valid/out_ready/out_data/out_index/out_last : consumer handshake
//   busy, overflow, clr_ovf   : status and sticky-drop flag with synchronous clear
//
// Build option: define MVM_Y_RELU_EN to clamp negative values to zero on out_data.

module mvm_y_collector #(
  parameter int K    = 16,
  parameter int logK = 4,
  parameter int b    = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  done,
  input  logic signed [2*b-1:0] data_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic signed [2*b-1:0] out_data,
  output logic [logK-1:0]       out_index,
  output logic                  out_last,
  output logic                  busy,
  output logic                  overflow,
  input  logic                  clr_ovf
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  localparam logic [logK-1:0] LAST_IDX = logK'(K - 1);
  localparam logic [logK-1:0] ONE      = logK'(1);
  localparam logic [logK-1:0] ZERO     = '0;

  state_t          state_q, state_d;
  logic [logK-1:0] cnt_q, cnt_d;
  logic [logK-1:0] rd_q, rd_d;
  logic            ovf_q, ovf_d;

  // Result storage: deliberately not reset, contents are only read after a full capture.
  logic signed [2*b-1:0] buf_q [K];

  logic                  buf_we;
  logic                  xfer;
  logic                  final_xfer;
  logic                  ovf_set;
  logic signed [2*b-1:0] rd_val;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rd_d       = rd_q;
    ovf_d      = ovf_q;
    ovf_set    = 1'b0;
    buf_we     = (state_q == CAPTURE);
    xfer       = (state_q == DRAIN) && out_ready;
    final_xfer = xfer && (rd_q == LAST_IDX);

    case (state_q)
      IDLE: begin
        if (done) begin
          state_d = CAPTURE;
          cnt_d   = ZERO;
        end
      end

      CAPTURE: begin
        // The upstream block cannot be stalled, so a new done here is lost.
        ovf_set = done;
        if (cnt_q == LAST_IDX) begin
          state_d = DRAIN;
          cnt_d   = ZERO;
          rd_d    = ZERO;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end

      DRAIN: begin
        // A done that coincides with the last beat can be taken immediately:
        // the buffer slot 0 write happens one cycle later, after the read finished.
        ovf_set = done && !final_xfer;
        if (xfer) begin
          if (final_xfer) begin
            rd_d = ZERO;
            if (done) begin
              state_d = CAPTURE;
              cnt_d   = ZERO;
            end else begin
              state_d = IDLE;
            end
          end else begin
            rd_d = rd_q + ONE;
          end
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = ZERO;
        rd_d    = ZERO;
      end
    endcase

    // Set has priority so a drop on the clearing cycle is not lost.
    if (clr_ovf) begin
      ovf_d = 1'b0;
    end
    if (ovf_set) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rd_q    <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (buf_we) begin
      buf_q[cnt_q] <= data_in;
    end
  end

  assign rd_val = buf_q[rd_q];

  always_comb begin
    out_valid = (state_q == DRAIN);
    busy      = (state_q != IDLE);
    out_index = rd_q;
    out_last  = out_valid && (rd_q == LAST_IDX);
    overflow  = ovf_q;
    out_data  = '0;
    if (out_valid) begin
`ifdef MVM_Y_RELU_EN
      out_data = rd_val[2*b-1] ? '0 : rd_val;
`else
      out_data = rd_val;
`endif
    end
  end

endmodule

// File: doc/mvm_y_collector.md
MVM_Y_COLLECTOR -- requirements
Module: mvm_y_collector

Interface
REQ-001 Parameter K, default 16: vector length, i.e. y entries per result.
REQ-002 Parameter logK, default 4: log2(K).
REQ-003 Parameter b, default 8: operand width; result width is 2*b.
REQ-004 clk  input  1  single clock, rising-edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 done  input  1  one-cycle pulse from the upstream mvm block; its first y value appears on data_in the next cycle.
REQ-007 data_in  input  2*b  signed y value from the upstream mvm output.
REQ-008 out_valid  output  1  out_data is valid.
REQ-009 out_ready  input  1  consumer accepts out_data.
REQ-010 out_data  output  2*b  signed y value presented to the consumer.
REQ-011 out_index  output  logK  row index of out_data.
REQ-012 out_last  output  1  high with out_valid when out_index==K-1.
REQ-013 busy  output  1  high in CAPTURE or DRAIN.
REQ-014 overflow  output  1  sticky flag: a result was dropped.
REQ-015 clr_ovf  input  1  synchronous clear of overflow.

Function
REQ-016 FSM states: IDLE, CAPTURE, DRAIN.
REQ-017 IDLE->CAPTURE on done=1; capture counter set to 0.
REQ-018 CAPTURE: data_in written to buffer[cnt] every cycle for K consecutive cycles, starting the cycle after done; no stalls.
REQ-019 CAPTURE->DRAIN after write of buffer[K-1]; read pointer set to 0.
REQ-020 DRAIN: out_valid=1, out_data=buffer[rd], out_index=rd.
REQ-021 Transfer occurs on a cycle with out_valid && out_ready; rd increments after each transfer.
REQ-022 out_data and out_index hold stable while out_valid=1 and out_ready=0.
REQ-023 Transfer at rd==K-1: next state IDLE, out_valid=0.
REQ-024 Minimum latency: first out_valid asserts K+1 cycles after the done cycle.
REQ-025 With out_ready held at 1, K beats complete in K consecutive cycles.
REQ-026 done=1 in CAPTURE or DRAIN: pulse ignored, current result unaffected, overflow set on the next edge.
REQ-027 done=1 on the same cycle as the final DRAIN transfer: treated as IDLE->CAPTURE, no overflow.
REQ-028 clr_ovf and an overflow event on the same cycle: overflow stays 1 (set wins).
REQ-029 Values are stored at full 2*b width; there is no arithmetic on the stored path except REQ-036.
REQ-030 Buffer is K x 2*b registers and is not cleared by reset.
REQ-031 busy = (state != IDLE).

Reset
REQ-032 reset=0 asynchronously forces IDLE and clears cnt, rd and overflow.
REQ-033 During reset: out_valid=0, out_last=0, busy=0, out_index=0, out_data=0.
REQ-034 Reset asserted mid-CAPTURE or mid-DRAIN abandons the partial result; no beat is emitted for it after release.
REQ-035 The first done is accepted on the first rising edge after reset deasserts.

Configuration
REQ-036 Macro MVM_Y_RELU_EN defined: out_data = 0 when buffer[rd] < 0, else buffer[rd]; out_index and out_last are unchanged.
REQ-037 Macro MVM_Y_RELU_EN undefined: out_data = buffer[rd] unmodified; no ReLU logic is synthesised.

Verification
REQ-038 done pulse, data_in = 0..15 on the next 16 cycles, out_ready=1 -> out_valid first high 17 cycles after done; out_data 0..15 on consecutive cycles; out_last only on index 15.
REQ-039 Same capture, out_ready toggling 1,0,1,0 -> each of 16 values emitted exactly once, in order; out_data stable while stalled.
REQ-040 Second done 5 cycles into DRAIN, out_ready=0 -> overflow=1; first result drains intact; clr_ovf=1 -> overflow=0 next cycle.
REQ-041 reset=0 pulsed at capture cycle 8, then full capture of 100..115 -> output is 100..115 only; no stale beats.
REQ-042 data_in alternating -300/+300, macro MVM_Y_RELU_EN defined -> out_data 0,300,0,300,...; macro undefined -> -300,300,...
REQ-043 done on the same cycle as the final transfer -> no overflow; next result captured and emitted.
